// File: rtl/phy_rx_unstripe_n_pkg.sv
// Shared types and default framing symbols for the serial receive front end.
package phy_rx_pkg;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    localparam logic [7:0] COM_DEFAULT = 8'hBC;
    localparam logic [7:0] IDL_DEFAULT = 8'h7C;

endpackage

// File: rtl/phy_rx_unstripe_n_if.sv
// Serial input and striped lane outputs; slave is the receiver side.
interface phy_rx_unstripe_n_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic                     in;
    logic [LANES*WIDTH-1:0]   out_lanes;
    logic [LANES-1:0]         valid_out;
    logic                     locked;
    logic                     idle;

    modport master (output in, input out_lanes, valid_out, locked, idle);
    modport slave  (input in, output out_lanes, valid_out, locked, idle);
endinterface

// File: rtl/phy_rx_unstripe_n_aligner.sv
// Bit-level COM hunt, symbol framing and lock tracking for the serial receiver.
module phy_rx_aligner
    import phy_rx_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_DEFAULT),
    parameter logic [WIDTH-1:0] IDL        = WIDTH'(IDL_DEFAULT),
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_GAP   = 64
) (
    input  logic             clk32f,
    input  logic             reset,
    input  logic             in,
    output logic [WIDTH-1:0] sym,
    output logic             sym_strobe,
    output logic             locked,
    output logic             is_com,
    output logic             is_idl,
    output logic             loss
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int GW = $clog2(LOSS_GAP + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    rx_state_t      r_state, w_state_nx;
    logic [WIDTH-1:0] r_sr;
    logic [BW-1:0]  r_bit, w_bit_nx;
    logic [CW-1:0]  r_com_cnt, w_com_cnt_nx;
    logic [GW-1:0]  r_gap, w_gap_nx;
    logic           w_boundary, w_com_match, w_gap_last;

    assign w_boundary  = (r_state == SEEK) || (r_bit == BIT_LAST);
    assign w_com_match = (r_sr == COM);
    assign w_gap_last  = (r_gap == GW'(LOSS_GAP - 1));

    always_ff @(posedge clk32f) begin
        if (!reset) begin
            r_state   <= SEEK;
            r_sr      <= '0;
            r_bit     <= '0;
            r_com_cnt <= '0;
            r_gap     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_sr      <= {r_sr[WIDTH-2:0], in};
            r_bit     <= w_bit_nx;
            r_com_cnt <= w_com_cnt_nx;
            r_gap     <= w_gap_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_bit_nx     = r_bit;
        w_com_cnt_nx = r_com_cnt;
        w_gap_nx     = r_gap;
        if (r_state != SEEK)
            w_bit_nx = (r_bit == BIT_LAST) ? '0 : r_bit + BW'(1);
        if (w_boundary) begin
            case (r_state)
                SEEK: begin
                    // Phase restarts here so the next boundary lands one symbol later.
                    if (w_com_match) begin
                        w_state_nx   = ALIGN;
                        w_com_cnt_nx = CW'(1);
                        w_bit_nx     = '0;
                    end
                end
                ALIGN: begin
                    if (w_com_match) begin
                        w_com_cnt_nx = r_com_cnt + CW'(1);
                        if (w_com_cnt_nx == CW'(LOCK_COUNT)) begin
                            w_state_nx = LOCKED;
                            w_gap_nx   = '0;
                        end
                    end else begin
                        w_state_nx   = SEEK;
                        w_com_cnt_nx = '0;
                    end
                end
                LOCKED: begin
                    if (w_com_match) begin
                        w_gap_nx = '0;
                    end else if (w_gap_last) begin
                        w_state_nx   = SEEK;
                        w_gap_nx     = '0;
                        w_com_cnt_nx = '0;
                    end else begin
                        w_gap_nx = r_gap + GW'(1);
                    end
                end
                default: w_state_nx = SEEK;
            endcase
        end
    end

    always_comb begin
        sym        = r_sr;
        is_com     = w_com_match;
        is_idl     = (r_sr == IDL);
        locked     = (r_state == LOCKED);
        sym_strobe = w_boundary && (r_state == LOCKED);
        loss       = sym_strobe && !w_com_match && w_gap_last;
    end
endmodule

// File: rtl/phy_rx_unstripe_n.sv
// N-lane serial receiver: aligns on COM and stripes data symbols across lanes.
module phy_rx_unstripe_n
    import phy_rx_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               LANES      = 4,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_DEFAULT),
    parameter logic [WIDTH-1:0] IDL        = WIDTH'(IDL_DEFAULT),
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_GAP   = 64
) (
    input  logic               clk32f,
    input  logic               reset,
    phy_rx_unstripe_n_if.slave bus
);
    localparam int LPW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [WIDTH-1:0]             w_sym;
    logic                         w_strobe, w_locked, w_is_com, w_is_idl, w_loss;
    logic [LANES-1:0][WIDTH-1:0]  r_buf;
    logic [LPW-1:0]               r_lp;
    logic [LANES*WIDTH-1:0]       r_out, w_word;
    logic [LANES-1:0]             r_valid, w_flush_mask;
    logic                         r_idle;

    phy_rx_aligner #(
        .WIDTH      (WIDTH),
        .COM        (COM),
        .IDL        (IDL),
        .LOCK_COUNT (LOCK_COUNT),
        .LOSS_GAP   (LOSS_GAP)
    ) u_aligner (
        .clk32f     (clk32f),
        .reset      (reset),
        .in         (bus.in),
        .sym        (w_sym),
        .sym_strobe (w_strobe),
        .locked     (w_locked),
        .is_com     (w_is_com),
        .is_idl     (w_is_idl),
        .loss       (w_loss)
    );

    // The completing symbol bypasses the buffer, which is only written at the same edge.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_word[g*WIDTH +: WIDTH] = (r_lp == LPW'(g)) ? w_sym : r_buf[g];
        assign w_flush_mask[g]          = (LPW'(g) < r_lp);
    end

    always_ff @(posedge clk32f) begin
        if (!reset) begin
            r_buf   <= '0;
            r_lp    <= '0;
            r_out   <= '0;
            r_valid <= '0;
            r_idle  <= 1'b0;
        end else begin
            r_valid <= '0;
            if (w_loss) begin
                r_lp   <= '0;
                r_idle <= 1'b0;
            end else if (w_strobe) begin
                if (w_is_com) begin
                    if (r_lp != '0) begin
                        r_out   <= r_buf;
                        r_valid <= w_flush_mask;
                    end
                    r_lp <= '0;
                end else if (w_is_idl) begin
                    r_idle <= 1'b1;
                end else begin
                    r_idle      <= 1'b0;
                    r_buf[r_lp] <= w_sym;
                    if (r_lp == LPW'(LANES - 1)) begin
                        r_out   <= w_word;
                        r_valid <= '1;
                        r_lp    <= '0;
                    end else begin
                        r_lp <= r_lp + LPW'(1);
                    end
                end
            end
        end
    end

    assign bus.out_lanes = r_out;
    assign bus.valid_out = r_valid;
    assign bus.locked    = w_locked;
    assign bus.idle      = r_idle;
endmodule

// File: doc/phy_rx_unstripe_n.md
# phy_rx_unstripe_n

Parametrised serial receive front end for the PCIe physical-layer path. It recovers symbol alignment from a single-bit serial stream by hunting for COM, deserialises aligned symbols, and un-stripes data symbols across `LANES` parallel outputs with per-lane valids. It is the single-clock, N-lane successor of the fixed four-lane `phy_rx`. It sits between the serial link input and the lane/byte consumers.

## Interface
- `WIDTH`, 8: symbol width in bits; serial data is MSB first.
- `LANES`, 4: number of output lanes; must be ≥ 1.
- `COM`, 8'hBC: alignment/framing symbol.
- `IDL`, 8'h7C: idle symbol.
- `LOCK_COUNT`, 4: consecutive aligned COMs required to reach lock.
- `LOSS_GAP`, 64: aligned symbols allowed without a COM before lock is dropped.

- `clk32f`, in, 1: bit-rate clock; the only clock.
- `reset`, in, 1: synchronous, active-low reset.
- `in`, in, 1: serial data, one bit per `clk32f`.
- `out_lanes`, out, `LANES*WIDTH`: lane k occupies bits [k*WIDTH +: WIDTH].
- `valid_out`, out, `LANES`: per-lane valid, one-cycle strobe.
- `locked`, out, 1: alignment locked.
- `idle`, out, 1: last aligned symbol received while locked was `IDL`.

## Operation
- Shift register `sr` loads one bit per cycle: `sr <= {sr[WIDTH-2:0], in}`.
- **Boundary:** a cycle in which `sr` holds a complete candidate symbol.
  - SEEK: every cycle is a boundary.
  - ALIGN and LOCKED: a boundary occurs every `WIDTH` cycles, measured from the boundary that matched COM in SEEK. A bit counter of width `$clog2(WIDTH)` tracks this and wraps to 0 at `WIDTH-1`.
- **SEEK:** at a boundary with `sr==COM`, set the COM count to 1, zero the bit phase and move to ALIGN.
- **ALIGN:**
  - At a boundary with `sr==COM`, increment the COM count. When it reaches `LOCK_COUNT`, move to LOCKED; `locked` goes to 1.
  - At a boundary with any other symbol, move to SEEK and clear the COM count.
  - No output activity in ALIGN.
- **LOCKED**, at each boundary:
  - **COM:** clear the gap counter.
    - If the lane pointer `lp` is not 0, flush the partial word: register the lane buffer to `out_lanes`, set `valid_out` bits [lp-1:0] to 1 and the rest to 0.
    - Set `lp` to 0. COM itself is never output.
  - **IDL:** set `idle` to 1. No striping; `lp` is unchanged.
  - **Data:** set `idle` to 0 and write the buffer: `buf[lp] <= sr`.
    - If `lp==LANES-1`: register the whole word to `out_lanes`, set `valid_out` to all ones and set `lp` to 0.
    - Otherwise increment `lp`.
  - **Gap counter:** increments on every non-COM boundary. When it reaches `LOSS_GAP`, go to SEEK:
    - `locked` goes to 0 and `idle` goes to 0;
    - `lp` is cleared and the partial word is discarded, not flushed.
- `valid_out` is 0 on every cycle that does not carry a word or flush. `out_lanes` holds its last value between strobes.

## Timing
- **Reset values:** `out_lanes`=0, `valid_out`=0, `locked`=0, `idle`=0. Internal state: `sr`=0, state=SEEK, all counters 0.
- **Reset mid-operation:** takes effect at the next edge. The partial word is discarded; re-lock needs `LOCK_COUNT` fresh COMs.
- **Latency:** the last bit of a symbol is sampled at edge k. The boundary action is registered at edge k+1, so `out_lanes`, `valid_out`, `locked` and `idle` change after edge k+1.
- **Lock timing:** `locked` rises one cycle after the `LOCK_COUNT`-th COM's last bit is sampled.
- **Single boundary per cycle:** there are no simultaneous symbol events. COM takes priority over the gap-limit check, so a COM arriving as the `LOSS_GAP`-th symbol keeps lock.
- **Counter widths:**
  - lane pointer: `$clog2(LANES)` bits, minimum 1;
  - gap counter: `$clog2(LOSS_GAP+1)` bits;
  - COM count: `$clog2(LOCK_COUNT+1)` bits.

## Structure
- Package `phy_rx_pkg`: state enum (SEEK, ALIGN, LOCKED) and default `COM`/`IDL` constants.
- Sub-module `phy_rx_aligner`:
  - contains `sr`, the FSM, the bit-phase, COM and gap counters;
  - outputs `sym[WIDTH-1:0]`, `sym_strobe` (a boundary while LOCKED), `locked`, `is_com` and `is_idl`.
- Top level: lane buffer, lane pointer, `out_lanes`/`valid_out`/`idle` registers.

## Test plan
All scenarios use the defaults: `WIDTH`=8, `LANES`=4.
1. **Reset:** hold `reset` low 3 cycles with random `in` → all outputs 0; `locked` stays 0 without COMs.
2. **Lock and full word:** 3 garbage bits, then BC×4, then FF, EE, DD, CC.
   - `locked` rises one cycle after the 4th BC.
   - `out_lanes`=32'hCCDDEEFF and `valid_out`=4'b1111 for exactly one cycle, one cycle after CC's last bit.
3. **Partial flush:** while locked, send AA, BB, BC → `valid_out`=4'b0011, lane0=AA, lane1=BB.
4. **Idle:** while locked, send 7C, 7C, then 11 → `idle` is 1 after the first 7C and returns to 0 after 11; `valid_out` stays 0 throughout.
5. **Lock rules:**
   - BC, BC, 55 → FSM returns to SEEK; `locked` never rises.
   - While locked, 64 consecutive non-COM data symbols → `locked` falls after the 64th; the pending partial word produces no `valid_out`.
6. **Reset mid-word:** locked, send AA, BB, pull `reset` low one cycle → outputs 0 and `locked` 0 next cycle; 4 BCs are needed to re-lock.
